udp_depacketizer: RTL and testbench
===================================

# udp_depacketizer

Receive-side counterpart of the IQ UDP transmit path. Accepts Ethernet frames byte-wise from the MAC receive interface and filters them on destination MAC/IP/port. For accepted frames it strips the Ethernet/IPv4/UDP headers and the 64-bit sequence field, reassembles 16-bit I/Q payload pairs into 32-bit samples, and writes them into the Serializer's input FIFO. It keeps saturating status counters for drops, overflows and sequence gaps.

## Interface
- `LOCAL_MAC`, 48'h02_12_34_56_78_90: accepted destination MAC; 48'hFFFF_FFFF_FFFF is also accepted.
- `LOCAL_IP`, {8'd192,8'd168,8'd50,8'd50}: accepted IPv4 destination.
- `LOCAL_PORT`, 16'd32179: accepted UDP destination port.

- `clk`  in  1  single clock; MAC RX and FIFO write side both run on it.
- `rst`  in  1  reset, asynchronous, active-low.
- `rx_data`  in  8  frame byte; FCS already stripped by the MAC.
- `rx_valid`  in  1  `rx_data` is valid this cycle. No backpressure exists.
- `rx_sop`  in  1  first byte of frame; qualified by `rx_valid`.
- `rx_eop`  in  1  last byte of frame; qualified by `rx_valid`.
- `rx_err`  in  1  frame error; qualified by `rx_valid`.
- `wr_en`  out  1  write strobe to the sample FIFO.
- `wr_data`  out  32  sample {I[15:0], Q[15:0]}.
- `wr_full`  in  1  FIFO full.
- `pkt_count`  out  16  accepted frames that reached `rx_eop` without error.
- `drop_count`  out  16  frames rejected by a header filter, by a short header, or by an error in the header/sequence section.
- `ovf_count`  out  16  samples lost because `wr_full` was set.
- `err_count`  out  16  `rx_err` seen during payload.
- `gap_count`  out  16  sequence discontinuities (see Configuration).

## Operation
- States:
  - IDLE: waits for `rx_valid & rx_sop`; that byte is byte 0 and the block moves to HDR.
  - HDR: bytes 0–41.
  - SEQ: bytes 42–49.
  - PAY: payload.
  - DRAIN: discards bytes until `rx_eop`, then returns to IDLE.
- An 11-bit byte index increments on each valid byte.
- Header checks, all of which must pass:
  - bytes 0–5 equal `LOCAL_MAC` or broadcast;
  - bytes 12–13 = 08 00;
  - byte 14 = 45;
  - byte 23 = 11;
  - bytes 30–33 = `LOCAL_IP`;
  - bytes 36–37 = `LOCAL_PORT`.
- The first failing check sends the block to DRAIN and increments `drop_count`. The IP checksum and UDP checksum are ignored.
- UDP length (bytes 38–39): if it is less than 16, the frame is dropped. Otherwise payload length = length − 16, in bytes.
- Sequence bytes 42–49 are little-endian.
- Payload byte order repeats per sample: I[7:0], I[15:8], Q[7:0], Q[15:8]. On the fourth byte, the sample is registered.
- Once the payload byte count is reached, the block moves to DRAIN. This discards Ethernet padding. A trailing partial sample (fewer than 4 bytes) is discarded.
- `rx_sop` in any state other than IDLE aborts the current frame and restarts at byte 0. The aborted frame counts in `drop_count` if it was in HDR or SEQ.
- `rx_eop` before the payload is complete returns the block to IDLE. This is a drop if it occurs in HDR or SEQ. In PAY, samples already written stand, and `pkt_count` increments.
- `rx_err` sends the block to IDLE:
  - in HDR or SEQ, it counts in `drop_count`;
  - in PAY, it counts in `err_count`, the partial sample is discarded, and samples already written are not retracted.
- All counters saturate at 16'hFFFF.

## Timing
- Reset values are 0 for every output, with the state at IDLE.
- `wr_en` is a one-cycle pulse in the cycle after the Q[15:8] byte is accepted, with `wr_data` valid in that same cycle.
- If `wr_full` is high in the cycle the sample completes, no write occurs and `ovf_count` increments.
- Counter updates are visible one cycle after the causing byte.
- Throughput is one byte per cycle; consecutive `rx_valid` cycles, and a new `rx_sop` on the cycle after `rx_eop`, must be accepted.

## Configuration
- `UDP_DEPACK_SEQ_CHECK_EN` defined:
  - The 64-bit sequence is captured.
  - The first accepted frame after reset sets expected = seq + 1.
  - For later frames, if seq ≠ expected, `gap_count` increments; expected is then set to seq + 1.
  - Expected updates only on frames that reach SEQ completion.
- Not defined: sequence bytes are skipped unexamined, and `gap_count` is tied to 0.

## Structure
- Shared package holds:
  - byte-offset constants for each header field;
  - EtherType/IP version/protocol constants;
  - the header length (42) and sequence length (8);
  - the state enum.
- One sub-module, `udp_hdr_filter`: takes byte index and byte and flags a mismatch per field.
- Counters are inline.

## Test plan
- Matching frame, UDP length 24 (2 samples), bytes I=1234, Q=ABCD then I=0001, Q=FFFF → two `wr_en` pulses with `wr_data` 1234ABCD then 0001FFFF; `pkt_count`=1.
- Destination port 0x1F40 → no `wr_en`; `drop_count`=1; the next matching frame is accepted.
- `wr_full` high across the second sample → exactly one write; `ovf_count`=1.
- `rx_err` on payload byte 6 → first sample written, second not; `err_count`=1; state returns to IDLE.
- `rx_sop` at byte 20 mid-header → `drop_count`=1; the new frame is parsed from byte 0 and accepted.
- With the macro defined: sequences 5, 6, 9 → `gap_count`=1. Without the macro: `gap_count`=0.

Source files
------------

// File: rtl/udp_depacketizer_pkg.sv
// Shared constants and types for the IQ UDP receive path.
package udp_depacketizer_pkg;

    localparam logic [10:0] OFF_DST_MAC  = 11'd0;
    localparam logic [10:0] OFF_ETYPE    = 11'd12;
    localparam logic [10:0] OFF_IP_VER   = 11'd14;
    localparam logic [10:0] OFF_PROTO    = 11'd23;
    localparam logic [10:0] OFF_DST_IP   = 11'd30;
    localparam logic [10:0] OFF_DST_PORT = 11'd36;
    localparam logic [10:0] OFF_UDP_LEN  = 11'd38;

    localparam logic [10:0] HDR_LEN = 11'd42;
    localparam logic [10:0] SEQ_LEN = 11'd8;

    localparam logic [15:0] ETYPE_IPV4   = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL   = 8'h45;
    localparam logic [7:0]  PROTO_UDP    = 8'h11;
    // UDP header (8) plus sequence field (8) precede the samples.
    localparam logic [15:0] UDP_OVERHEAD = 16'd16;

    typedef enum logic [2:0] {StIdle, StHdr, StSeq, StPay, StDrain} state_e;

    function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, cnt} + {15'b0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/udp_depacketizer_hdr_filter.sv
// Per-byte header field comparison; flags which field the current byte violates.
module udp_hdr_filter
    import udp_depacketizer_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC  = 48'h02_12_34_56_78_90,
    parameter logic [31:0] LOCAL_IP   = {8'd192, 8'd168, 8'd50, 8'd50},
    parameter logic [15:0] LOCAL_PORT = 16'd32179
) (
    input  logic [10:0] idx,
    input  logic [7:0]  data,
    output logic        mac_local_mis,
    output logic        mac_bcast_mis,
    output logic        etype_mis,
    output logic        ver_mis,
    output logic        proto_mis,
    output logic        ip_mis,
    output logic        port_mis
);

    logic [10:0] mac_off;
    logic [10:0] ip_off;
    logic [47:0] mac_sh;
    logic [31:0] ip_sh;

    always_comb begin
        mac_off       = idx - OFF_DST_MAC;
        ip_off        = idx - OFF_DST_IP;
        // Shift the wanted byte to the top so no variable part-select is needed.
        mac_sh        = LOCAL_MAC << {mac_off[2:0], 3'b000};
        ip_sh         = LOCAL_IP << {ip_off[1:0], 3'b000};
        mac_local_mis = 1'b0;
        mac_bcast_mis = 1'b0;
        etype_mis     = 1'b0;
        ver_mis       = 1'b0;
        proto_mis     = 1'b0;
        ip_mis        = 1'b0;
        port_mis      = 1'b0;
        if (idx < OFF_DST_MAC + 11'd6) begin
            mac_local_mis = data != mac_sh[47:40];
            mac_bcast_mis = data != 8'hFF;
        end
        if (idx == OFF_ETYPE)         etype_mis = data != ETYPE_IPV4[15:8];
        if (idx == OFF_ETYPE + 11'd1) etype_mis = data != ETYPE_IPV4[7:0];
        if (idx == OFF_IP_VER)        ver_mis   = data != IP_VER_IHL;
        if (idx == OFF_PROTO)         proto_mis = data != PROTO_UDP;
        if (idx >= OFF_DST_IP && idx < OFF_DST_IP + 11'd4) ip_mis = data != ip_sh[31:24];
        if (idx == OFF_DST_PORT)         port_mis = data != LOCAL_PORT[15:8];
        if (idx == OFF_DST_PORT + 11'd1) port_mis = data != LOCAL_PORT[7:0];
    end

endmodule

// File: rtl/udp_depacketizer.sv
// Filters IQ UDP frames, strips headers and writes 32-bit {I,Q} samples to the FIFO.
// Optional sequence-gap checking is enabled by defining UDP_DEPACK_SEQ_CHECK_EN.
module udp_depacketizer
    import udp_depacketizer_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC  = 48'h02_12_34_56_78_90,
    parameter logic [31:0] LOCAL_IP   = {8'd192, 8'd168, 8'd50, 8'd50},
    parameter logic [15:0] LOCAL_PORT = 16'd32179
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_sop,
    input  logic        rx_eop,
    input  logic        rx_err,
    output logic        wr_en,
    output logic [31:0] wr_data,
    input  logic        wr_full,
    output logic [15:0] pkt_count,
    output logic [15:0] drop_count,
    output logic [15:0] ovf_count,
    output logic [15:0] err_count,
    output logic [15:0] gap_count
);

    state_e      state_q, state_d, eff_state;
    logic [10:0] idx_q, idx_d, eff_idx;
    logic [15:0] len_q, len_d, pay_len;
    logic [15:0] pay_cnt_q, pay_cnt_d;
    logic [1:0]  lane_q, lane_d;
    logic [23:0] samp_q, samp_d;
    logic        mac_lbad_q, mac_lbad_d, mac_bbad_q, mac_bbad_d;
    logic        accepted_q, accepted_d;
    logic        wr_en_q, wr_en_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [15:0] pkt_q, drop_q, ovf_q, err_q;
    logic        start, bad, short_len;
    logic        pkt_inc, ovf_inc, err_inc, gap_inc;
    logic [1:0]  drop_inc;

    logic mac_local_mis, mac_bcast_mis, etype_mis, ver_mis, proto_mis, ip_mis, port_mis;

    udp_hdr_filter #(
        .LOCAL_MAC  (LOCAL_MAC),
        .LOCAL_IP   (LOCAL_IP),
        .LOCAL_PORT (LOCAL_PORT)
    ) u_hdr_filter (
        .idx           (eff_idx),
        .data          (rx_data),
        .mac_local_mis (mac_local_mis),
        .mac_bcast_mis (mac_bcast_mis),
        .etype_mis     (etype_mis),
        .ver_mis       (ver_mis),
        .proto_mis     (proto_mis),
        .ip_mis        (ip_mis),
        .port_mis      (port_mis)
    );

`ifdef UDP_DEPACK_SEQ_CHECK_EN
    logic [55:0] seq_q, seq_d;
    logic [63:0] exp_q, exp_d, seq_full;
    logic        seen_q, seen_d;
    logic [15:0] gap_q;
    assign gap_count = gap_q;
`else
    assign gap_count = 16'h0000;
`endif

    assign pay_len = len_q - UDP_OVERHEAD;

    always_comb begin
        start      = rx_valid & rx_sop;
        // A start-of-frame in any state is treated as byte 0 of a fresh header.
        eff_state  = start ? StHdr : state_q;
        eff_idx    = start ? 11'd0 : idx_q;
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        pay_cnt_d  = pay_cnt_q;
        lane_d     = lane_q;
        samp_d     = samp_q;
        mac_lbad_d = mac_lbad_q;
        mac_bbad_d = mac_bbad_q;
        accepted_d = accepted_q;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        bad        = 1'b0;
        short_len  = 1'b0;
        pkt_inc    = 1'b0;
        ovf_inc    = 1'b0;
        err_inc    = 1'b0;
        gap_inc    = 1'b0;
        drop_inc   = {1'b0, start && (state_q == StHdr || state_q == StSeq)};
`ifdef UDP_DEPACK_SEQ_CHECK_EN
        seq_d    = seq_q;
        exp_d    = exp_q;
        seen_d   = seen_q;
        seq_full = {rx_data, seq_q};
`endif
        if (rx_valid) begin
            idx_d = eff_idx + 11'd1;
            unique case (eff_state)
                StIdle: idx_d = idx_q;
                StHdr: begin
                    mac_lbad_d = (start ? 1'b0 : mac_lbad_q) | mac_local_mis;
                    mac_bbad_d = (start ? 1'b0 : mac_bbad_q) | mac_bcast_mis;
                    accepted_d = 1'b0;
                    if (eff_idx == OFF_UDP_LEN)         len_d[15:8] = rx_data;
                    if (eff_idx == OFF_UDP_LEN + 11'd1) begin
                        len_d[7:0] = rx_data;
                        short_len  = {len_q[15:8], rx_data} < UDP_OVERHEAD;
                    end
                    bad = (mac_lbad_d & mac_bbad_d) | etype_mis | ver_mis | proto_mis |
                          ip_mis | port_mis | short_len | rx_err | rx_eop;
                    if (bad) begin
                        drop_inc = drop_inc + 2'd1;
                        state_d  = (rx_err | rx_eop) ? StIdle : StDrain;
                    end else begin
                        state_d = (eff_idx == HDR_LEN - 11'd1) ? StSeq : StHdr;
                    end
                end
                StSeq: begin
`ifdef UDP_DEPACK_SEQ_CHECK_EN
                    seq_d = seq_full[63:8];
`endif
                    if (rx_err | rx_eop) begin
                        drop_inc = drop_inc + 2'd1;
                        state_d  = StIdle;
                    end else if (idx_q == HDR_LEN + SEQ_LEN - 11'd1) begin
`ifdef UDP_DEPACK_SEQ_CHECK_EN
                        gap_inc = seen_q && (seq_full != exp_q);
                        exp_d   = seq_full + 64'd1;
                        seen_d  = 1'b1;
`endif
                        pay_cnt_d  = 16'd0;
                        lane_d     = 2'd0;
                        accepted_d = (pay_len == 16'd0);
                        state_d    = (pay_len == 16'd0) ? StDrain : StPay;
                    end
                end
                StPay: begin
                    if (rx_err) begin
                        err_inc = 1'b1;
                        state_d = StIdle;
                    end else begin
                        lane_d    = lane_q + 2'd1;
                        pay_cnt_d = pay_cnt_q + 16'd1;
                        unique case (lane_q)
                            2'd0: samp_d[7:0]   = rx_data;
                            2'd1: samp_d[15:8]  = rx_data;
                            2'd2: samp_d[23:16] = rx_data;
                            2'd3: begin
                                if (wr_full) begin
                                    ovf_inc = 1'b1;
                                end else begin
                                    wr_en_d   = 1'b1;
                                    wr_data_d = {samp_q[15:0], rx_data, samp_q[23:16]};
                                end
                            end
                        endcase
                        if (rx_eop) begin
                            pkt_inc = 1'b1;
                            state_d = StIdle;
                        end else if (pay_cnt_d == pay_len) begin
                            accepted_d = 1'b1;
                            state_d    = StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (rx_eop | rx_err) begin
                        pkt_inc = rx_eop & ~rx_err & accepted_q;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            len_q      <= '0;
            pay_cnt_q  <= '0;
            lane_q     <= '0;
            samp_q     <= '0;
            mac_lbad_q <= 1'b0;
            mac_bbad_q <= 1'b0;
            accepted_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            pkt_q      <= '0;
            drop_q     <= '0;
            ovf_q      <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            pay_cnt_q  <= pay_cnt_d;
            lane_q     <= lane_d;
            samp_q     <= samp_d;
            mac_lbad_q <= mac_lbad_d;
            mac_bbad_q <= mac_bbad_d;
            accepted_q <= accepted_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            pkt_q      <= sat_add(pkt_q, {1'b0, pkt_inc});
            drop_q     <= sat_add(drop_q, drop_inc);
            ovf_q      <= sat_add(ovf_q, {1'b0, ovf_inc});
            err_q      <= sat_add(err_q, {1'b0, err_inc});
        end
    end

`ifdef UDP_DEPACK_SEQ_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq_q  <= '0;
            exp_q  <= '0;
            seen_q <= 1'b0;
            gap_q  <= '0;
        end else begin
            seq_q  <= seq_d;
            exp_q  <= exp_d;
            seen_q <= seen_d;
            gap_q  <= sat_add(gap_q, {1'b0, gap_inc});
        end
    end
`else
    logic unused_gap;
    assign unused_gap = gap_inc;
`endif

    assign wr_en      = wr_en_q;
    assign wr_data    = wr_data_q;
    assign pkt_count  = pkt_q;
    assign drop_count = drop_q;
    assign ovf_count  = ovf_q;
    assign err_count  = err_q;

endmodule

// File: tb/tb_udp_depacketizer.sv
// Directed bench for udp_depacketizer: filtering, sample reassembly, counters.
module tb_udp_depacketizer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0, rx_sop = 1'b0, rx_eop = 1'b0, rx_err = 1'b0;
    logic        wr_full = 1'b0;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [15:0] pkt_count, drop_count, ovf_count, err_count, gap_count;

    int checks = 0;
    int errors = 0;
    int n_wr = 0;
    int base;
    logic [31:0] wr_log [0:63];
    logic [7:0]  fb [0:59];
    logic [15:0] exp_gap;

    always #5 clk = ~clk;

    udp_depacketizer dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_sop     (rx_sop),
        .rx_eop     (rx_eop),
        .rx_err     (rx_err),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_full    (wr_full),
        .pkt_count  (pkt_count),
        .drop_count (drop_count),
        .ovf_count  (ovf_count),
        .err_count  (err_count),
        .gap_count  (gap_count)
    );

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (n_wr < 64) wr_log[n_wr] = wr_data;
            n_wr = n_wr + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic build(input logic [47:0] mac, input logic [15:0] port,
                         input logic [15:0] ulen, input logic [63:0] seq);
        for (int i = 0; i < 60; i++) fb[i] = 8'h00;
        for (int i = 0; i < 6; i++) fb[i] = mac[47 - 8*i -: 8];
        for (int i = 6; i < 12; i++) fb[i] = 8'(8'h10 + i);
        fb[12] = 8'h08; fb[13] = 8'h00; fb[14] = 8'h45; fb[22] = 8'h40; fb[23] = 8'h11;
        fb[26] = 8'hC0; fb[27] = 8'hA8; fb[28] = 8'h32; fb[29] = 8'h01;
        fb[30] = 8'hC0; fb[31] = 8'hA8; fb[32] = 8'h32; fb[33] = 8'h32;
        fb[34] = 8'h12; fb[35] = 8'h34;
        fb[36] = port[15:8]; fb[37] = port[7:0];
        fb[38] = ulen[15:8]; fb[39] = ulen[7:0];
        for (int i = 0; i < 8; i++) fb[42 + i] = seq[8*i +: 8];
        fb[50] = 8'h34; fb[51] = 8'h12; fb[52] = 8'hCD; fb[53] = 8'hAB;
        fb[54] = 8'h01; fb[55] = 8'h00; fb[56] = 8'hFF; fb[57] = 8'hFF;
    endtask

    task automatic send(input int nbytes, input bit with_eop, input int err_at,
                        input int full_lo, input int full_hi);
        for (int i = 0; i < nbytes; i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = fb[i];
            rx_sop   = (i == 0);
            rx_eop   = with_eop && (i == nbytes - 1);
            rx_err   = (i == err_at);
            wr_full  = (i >= full_lo) && (i <= full_hi);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; rx_err = 1'b0; wr_full = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
        idle(1);
        base = n_wr;
    endtask

    initial begin
        do_reset();
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_wr_data", wr_data, 32'h0);
        check("rst_pkt", pkt_count, 16'd0);
        check("rst_drop", drop_count, 16'd0);
        check("rst_ovf", ovf_count, 16'd0);
        check("rst_err", err_count, 16'd0);
        check("rst_gap", gap_count, 16'd0);

        // Two-sample frame padded to 60 bytes.
        build(48'h021234567890, 16'd32179, 16'd24, 64'd1);
        send(60, 1'b1, -1, -1, -1);
        idle(3);
        check("basic_nwr", n_wr - base, 2);
        check("basic_s0", wr_log[base], 32'h1234ABCD);
        check("basic_s1", wr_log[base + 1], 32'h0001FFFF);
        check("basic_pkt", pkt_count, 16'd1);
        check("basic_drop", drop_count, 16'd0);

        // Wrong port, then a good frame back-to-back.
        do_reset();
        build(48'h021234567890, 16'h1F40, 16'd24, 64'd1);
        send(60, 1'b1, -1, -1, -1);
        build(48'h021234567890, 16'd32179, 16'd24, 64'd2);
        send(60, 1'b1, -1, -1, -1);
        idle(3);
        check("port_drop", drop_count, 16'd1);
        check("port_nwr", n_wr - base, 2);
        check("port_pkt", pkt_count, 16'd1);

        // FIFO full during second sample.
        do_reset();
        build(48'h021234567890, 16'd32179, 16'd24, 64'd1);
        send(60, 1'b1, -1, 54, 57);
        idle(3);
        check("full_nwr", n_wr - base, 1);
        check("full_s0", wr_log[base], 32'h1234ABCD);
        check("full_ovf", ovf_count, 16'd1);
        check("full_pkt", pkt_count, 16'd1);

        // rx_err on payload byte 6, then a good frame.
        do_reset();
        build(48'h021234567890, 16'd32179, 16'd24, 64'd1);
        send(60, 1'b1, 56, -1, -1);
        idle(3);
        check("err_nwr", n_wr - base, 1);
        check("err_cnt", err_count, 16'd1);
        check("err_pkt", pkt_count, 16'd0);
        check("err_drop", drop_count, 16'd0);
        send(60, 1'b1, -1, -1, -1);
        idle(3);
        check("err_next_pkt", pkt_count, 16'd1);
        check("err_next_nwr", n_wr - base, 3);

        // New SOP at byte 20 of the header.
        do_reset();
        build(48'h021234567890, 16'd32179, 16'd24, 64'd1);
        send(20, 1'b0, -1, -1, -1);
        send(60, 1'b1, -1, -1, -1);
        idle(3);
        check("sop_drop", drop_count, 16'd1);
        check("sop_pkt", pkt_count, 16'd1);
        check("sop_nwr", n_wr - base, 2);

        // UDP length 15 is too short; broadcast MAC is accepted.
        do_reset();
        build(48'h021234567890, 16'd32179, 16'd15, 64'd1);
        send(60, 1'b1, -1, -1, -1);
        build(48'hFFFFFFFFFFFF, 16'd32179, 16'd24, 64'd2);
        send(60, 1'b1, -1, -1, -1);
        idle(3);
        check("len_drop", drop_count, 16'd1);
        check("bcast_pkt", pkt_count, 16'd1);
        check("bcast_nwr", n_wr - base, 2);

        // Sequences 5, 6, 9.
        do_reset();
        build(48'h021234567890, 16'd32179, 16'd24, 64'd5);
        send(60, 1'b1, -1, -1, -1);
        build(48'h021234567890, 16'd32179, 16'd24, 64'd6);
        send(60, 1'b1, -1, -1, -1);
        build(48'h021234567890, 16'd32179, 16'd24, 64'd9);
        send(60, 1'b1, -1, -1, -1);
        idle(3);
`ifdef UDP_DEPACK_SEQ_CHECK_EN
        exp_gap = 16'd1;
`else
        exp_gap = 16'd0;
`endif
        check("seq_gap", gap_count, exp_gap);
        check("seq_pkt", pkt_count, 16'd3);
        check("seq_nwr", n_wr - base, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
